// File: rtl/evolve_ctrl.sv
// Creature evolution controller: accumulates battle XP and hands evolutions
// to a downstream animation stage through a start/done handshake.
module evolve_ctrl #(
  parameter logic [9:0] EVO_XP    = 10'd100,
  parameter logic [1:0] MAX_STAGE = 2'd2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_in,
  input  logic [7:0] base_sprite_in,
  input  logic       win_in,
  input  logic [7:0] xp_gain_in,
  input  logic       evolve_done_in,
  output logic       evolve_start_out,
  output logic [7:0] sprite_out,
  output logic [9:0] xp_out,
  output logic [1:0] stage_out,
  output logic       busy_out
);

  typedef enum logic [1:0] {IDLE, CHECK, EVOLVING, COMMIT} state_t;

  state_t     state, state_d;
  logic [9:0] xp, xp_d, pending, pending_d;
  logic [7:0] sprite, sprite_d;
  logic [1:0] stage, stage_d;
  logic       start, start_d, busy;
  logic       evolve_ok;

  function automatic logic [9:0] sat_xp(input logic [11:0] v);
    return (v > 12'd1023) ? 10'h3FF : v[9:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign evolve_ok = (xp >= EVO_XP) && (stage < MAX_STAGE);

  // State and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      xp      <= '0;
      pending <= '0;
      sprite  <= '0;
      stage   <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      xp      <= xp_d;
      pending <= pending_d;
      sprite  <= sprite_d;
      stage   <= stage_d;
      start   <= start_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state;
    if (load_in) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:     if (win_in || pending != '0) state_d = CHECK;
        CHECK:    state_d = evolve_ok ? EVOLVING : IDLE;
        EVOLVING: if (evolve_done_in) state_d = COMMIT;
        COMMIT:   state_d = CHECK;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    xp_d      = xp;
    pending_d = pending;
    sprite_d  = sprite;
    stage_d   = stage;
    start_d   = start;
    if (load_in) begin
      // Load wins over everything, including a same-cycle win
      sprite_d  = base_sprite_in;
      xp_d      = '0;
      pending_d = '0;
      stage_d   = '0;
      start_d   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_in) begin
            xp_d      = sat_xp({2'b0, xp} + {2'b0, pending} + {4'b0, xp_gain_in});
            pending_d = '0;
          end else if (pending != '0) begin
            xp_d      = sat_xp({2'b0, xp} + {2'b0, pending});
            pending_d = '0;
          end
        end
        CHECK: begin
          if (evolve_ok) begin
            xp_d    = xp - EVO_XP;
            start_d = 1'b1;
          end
        end
        EVOLVING: if (evolve_done_in) start_d = 1'b0;
        COMMIT: begin
          sprite_d = sat_inc8(sprite);
          stage_d  = stage + 2'd1;
        end
        default: ;
      endcase
      // Wins arriving while busy are parked until the FSM is back in IDLE
      if (state != IDLE && win_in)
        pending_d = sat_xp({2'b0, pending} + {4'b0, xp_gain_in});
    end
  end

  assign evolve_start_out = start;
  assign sprite_out       = sprite;
  assign xp_out           = xp;
  assign stage_out        = stage;
  assign busy_out         = busy;

endmodule

// File: doc/evolve_ctrl.md
EVOLVE_CTRL -- requirements
Module: evolve_ctrl

Interface
REQ-001 Parameter EVO_XP, default 10'd100, XP threshold consumed per evolution.
REQ-002 Parameter MAX_STAGE, default 2'd2, evolutions allowed per loaded creature.
REQ-003 clk_in  input  1  single system clock; all logic on posedge clk_in.
REQ-004 rst_in  input  1  reset, synchronous, active-low.
REQ-005 load_in  input  1  one-cycle pulse: load a new creature.
REQ-006 base_sprite_in  input  8  sprite index of the creature being loaded, sampled on load_in.
REQ-007 win_in  input  1  one-cycle pulse: battle won.
REQ-008 xp_gain_in  input  8  XP awarded, sampled with win_in.
REQ-009 evolve_done_in  input  1  done from the downstream evolution animation stage.
REQ-010 evolve_start_out  output  1  level start to the animation stage.
REQ-011 sprite_out  output  8  current sprite index, fed to the animation stage as sprite_in.
REQ-012 xp_out  output  10  current accumulated XP.
REQ-013 stage_out  output  2  evolutions completed since load.
REQ-014 busy_out  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CHECK, EVOLVING, COMMIT; the state register and all outputs SHALL be registered.
REQ-016 IDLE + win_in: xp <= min(xp + pending + xp_gain_in, 1023); pending <= 0; next state CHECK.
REQ-017 IDLE, no win_in, pending != 0: xp <= min(xp + pending, 1023); pending <= 0; next state CHECK.
REQ-018 win_in outside IDLE: pending <= min(pending + xp_gain_in, 1023); no state change.
REQ-019 CHECK: if xp >= EVO_XP and stage < MAX_STAGE, then xp <= xp - EVO_XP, evolve_start_out <= 1, next state EVOLVING; otherwise next state IDLE.
REQ-020 Latency: win_in at cycle N -> xp_out updated and busy_out high at N+1 -> evolve_start_out high at N+2 when the threshold is met.
REQ-021 EVOLVING: evolve_start_out SHALL stay high until evolve_done_in is sampled high; then evolve_start_out <= 0 and next state COMMIT.
REQ-022 evolve_done_in outside EVOLVING SHALL be ignored.
REQ-023 COMMIT: sprite <= sprite + 1, saturating at 8'hFF; stage <= stage + 1; next state CHECK, so that remaining XP can trigger a chained evolution.
REQ-024 load_in has priority in every state: sprite <= base_sprite_in, xp <= 0, stage <= 0, pending <= 0, evolve_start_out <= 0, next state IDLE; a win_in in the same cycle is dropped.
REQ-025 No evolution SHALL start once stage_out == MAX_STAGE; XP keeps accumulating, saturating at 1023.
REQ-026 Sprite, XP and stage SHALL change only in the cases listed in REQ-016 to REQ-024.

Reset
REQ-027 rst_in low at a clock edge: state IDLE; evolve_start_out 0; busy_out 0; sprite_out 0; xp_out 0; stage_out 0; pending 0.
REQ-028 Reset SHALL override load_in and all other inputs, including mid-EVOLVING, and drops evolve_start_out on the next edge.

Verification
REQ-029 load_in with base_sprite_in = 8'd4, then win_in with xp_gain_in = 8'd60 -> xp_out = 60, no start, busy_out high for 1 cycle only.
REQ-030 From xp = 60, win_in with gain 50 at N -> xp_out = 110 at N+1; evolve_start_out high at N+2 with xp_out = 10; done pulse -> start low, sprite_out 4 -> 5, stage_out = 1, then back to IDLE.
REQ-031 Load, then win_in with gain 8'd250 twice (xp 500) -> two chained evolutions, sprite_out +2, stage_out = 2, xp_out = 300; a further win adds XP with no start.
REQ-032 win_in with gain 30 while EVOLVING -> xp_out unchanged until return to IDLE, then +30 applied and CHECK re-run.
REQ-033 load_in while EVOLVING -> evolve_start_out low on the next cycle, outputs reloaded, a subsequent evolve_done_in is ignored.
REQ-034 rst_in low for 1 cycle while EVOLVING -> all outputs 0 on the next cycle; sprite saturation: base_sprite_in = 8'hFF, evolve -> sprite_out stays 8'hFF, stage_out increments.
